retire_wb: RTL and testbench
============================

// Module: retire_wb
//
// PURPOSE
//  Consumer end of the execute-stage output interface: takes uinstr_ex1/result_ex1 at RB0,
//  registers them into RB1, performs the register-file writeback and retires the uop.
//  Detects retiring branch mispredictions and drives br_mispred_rb1/br_tgt_rb1 back to
//  execute (which kills its uinstr_ex1.valid in the same cycle) and to fetch (redirect).
//  Runs a flush FSM that squashes wrong-path uops, and keeps the retire/mispredict counters.
//
// PARAMETERS
//  FLUSH_CYCLES  3   cycles after a redirect during which arriving uops are squashed (>=1)
//  CNT_W         64  width of the instret counter
//  MCNT_W        32  width of the mispredict counter
//
// PORTS
//  clk             in   1              clock
//  reset           in   1              synchronous, active-high reset
//  stall           in   1              pipeline stall; all state holds
//  uinstr_ex1      in   t_uinstr       uop from execute (valid, dst, mispred used)
//  result_ex1      in   t_rv_reg_data  ALU result, or branch target for branches
//  br_mispred_rb1  out  1              one-cycle redirect pulse
//  br_tgt_rb1      out  t_paddr        redirect target, meaningful only with br_mispred_rb1
//  rfwr_en_rb1     out  1              register-file write enable
//  rfwr_addr_rb1   out  5              destination architectural register
//  rfwr_data_rb1   out  t_rv_reg_data  writeback data
//  flushing_rb1    out  1              FSM is in FLUSH
//  instret         out  CNT_W          count of retired (non-squashed) uops
//  mispred_cnt     out  MCNT_W         count of redirects taken
//
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=RUN, flush counter 0, instret=0, mispred_cnt=0.
//  - RB0 is combinational on the _ex1 inputs. accept_rb0 = uinstr_ex1.valid & ~stall & state==RUN.
//  - RB1 is one flop stage. Latency is one cycle from an _ex1 input to the matching _rb1 output.
//  - Writeback:
//      rfwr_en_rb1   <= accept_rb0 & dst.optype==OP_REG & dst.opreg!=0 & ~mispred.
//      rfwr_addr_rb1 <= dst.opreg.
//      rfwr_data_rb1 <= result_ex1.
//      x0 is never written.
//  - Redirect:
//      br_mispred_rb1 <= accept_rb0 & uinstr_ex1.mispred.
//      br_tgt_rb1     <= result_ex1[t_paddr width-1:0].
//      The pulse lasts exactly one cycle.
//      A mispredicting uop still counts toward instret.
//      A mispredicting uop never writes the register file.
//  - instret increments by 1 per accepted uop and wraps mod 2^CNT_W.
//  - mispred_cnt increments by 1 per redirect and saturates at all-ones.
//  - FSM:
//      RUN   -> FLUSH on an accepted mispredict. Counter loads FLUSH_CYCLES.
//      FLUSH: counter decrements each non-stalled cycle. Returns to RUN on the cycle the
//             counter reaches 1.
//      FLUSH: valid uops arriving in FLUSH are squashed. They do not write, do not count,
//             and do not redirect, including further mispredicts.
//      flushing_rb1 = (state==FLUSH).
//  - stall=1:
//      RB1 data regs, FSM, counter and counters all hold.
//      rfwr_en_rb1 and br_mispred_rb1 drop to 0, so no duplicate write or redirect occurs.
//  - Simultaneous events:
//      stall + mispred: stall wins, and the uop is presented again next cycle.
//      Reset mid-FLUSH returns to RUN with counters cleared.
//  - ASSERT: br_mispred_rb1 |-> ~rfwr_en_rb1. No redirect while flushing_rb1 was 1 the prior cycle.
//
// TESTING
//  1. Sequence: ADDI x5 with result 0x1234, then x0 dst with 0xFFFF.
//     Required: cycle+1 shows rfwr_en=1, addr=5, data=0x1234; next cycle rfwr_en=0.
//     instret ends at 2.
//  2. Branch with mispred=1 and result 0x8000_0040.
//     Required: br_mispred_rb1=1 for 1 cycle with br_tgt=0x8000_0040; flushing=1 for 3 cycles.
//     mispred_cnt=1 and instret=1.
//  3. Valid uops every cycle during FLUSH (FLUSH_CYCLES=3), one of them mispred=1.
//     Required: none write, none count, no second redirect; RUN resumes on the 4th cycle.
//  4. stall=1 for 2 cycles while a valid ADD x7 is held.
//     Required: a single rfwr_en pulse after stall drops; instret +1, not +3.
//  5. Assert reset in the 2nd FLUSH cycle.
//     Required: next cycle flushing=0, instret=0, mispred_cnt=0, all _rb1 outputs 0.
//  6. Preload instret=2^64-1, then retire 1 uop.
//     Required: instret=0.
//     Separately, force mispred_cnt to all-ones and take a redirect: mispred_cnt holds at all-ones.

Source files
------------

// File: rtl/retire_wb.sv
// Retire/writeback stage: registers the execute-stage uop into RB1, writes the RF, redirects on mispredict, squashes wrong path.
// Latency: one cycle from uinstr_ex1/result_ex1 to every _rb1 output; counters update on the same edge.
// Backpressure: stall holds all state and suppresses write/redirect pulses; uops arriving while flushing are dropped.
module retire_wb #(
    parameter int FLUSH_CYCLES = 3,
    parameter int CNT_W        = 64,
    parameter int MCNT_W       = 32,
    parameter int XLEN         = 64,
    parameter int PADDR_W      = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    // uop layout: [8] valid, [7] mispred, [6:5] dst optype, [4:0] dst opreg
    input  logic [8:0]         uinstr_ex1,
    input  logic [XLEN-1:0]    result_ex1,
    output logic               br_mispred_rb1,
    output logic [PADDR_W-1:0] br_tgt_rb1,
    output logic               rfwr_en_rb1,
    output logic [4:0]         rfwr_addr_rb1,
    output logic [XLEN-1:0]    rfwr_data_rb1,
    output logic               flushing_rb1,
    output logic [CNT_W-1:0]   instret,
    output logic [MCNT_W-1:0]  mispred_cnt
);

    localparam int             FCW        = $clog2(FLUSH_CYCLES + 1);
    localparam logic [FCW-1:0] FLUSH_LOAD = FCW'(FLUSH_CYCLES);
    localparam logic [FCW-1:0] FCNT_ONE   = FCW'(1);
    localparam logic [1:0]     OP_REG     = 2'd1;

    typedef enum logic {ST_RUN, ST_FLUSH} state_t;

    state_t             state_q, state_d;
    logic [FCW-1:0]     flush_cnt_q, flush_cnt_d;
    logic               rfwr_en_q, rfwr_en_d;
    logic [4:0]         rfwr_addr_q, rfwr_addr_d;
    logic [XLEN-1:0]    rfwr_data_q, rfwr_data_d;
    logic               br_mispred_q, br_mispred_d;
    logic [PADDR_W-1:0] br_tgt_q, br_tgt_d;
    logic [CNT_W-1:0]   instret_q, instret_d;
    logic [MCNT_W-1:0]  mispred_cnt_q, mispred_cnt_d;

    logic       ui_valid, ui_mispred;
    logic [1:0] ui_optype;
    logic [4:0] ui_opreg;
    logic       accept_rb0;

    assign ui_valid   = uinstr_ex1[8];
    assign ui_mispred = uinstr_ex1[7];
    assign ui_optype  = uinstr_ex1[6:5];
    assign ui_opreg   = uinstr_ex1[4:0];

    // Only uops seen in RUN and not stalled are real; anything else is either retried or wrong-path.
    assign accept_rb0 = ui_valid & ~stall & (state_q == ST_RUN);

    // Flush FSM: a retiring mispredict opens a fixed squash window that only advances on non-stalled cycles.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        if (!stall) begin
            case (state_q)
                ST_RUN: begin
                    if (accept_rb0 && ui_mispred) begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = FLUSH_LOAD;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt_q == FCNT_ONE) begin
                        state_d     = ST_RUN;
                        flush_cnt_d = '0;
                    end else begin
                        flush_cnt_d = flush_cnt_q - FCNT_ONE;
                    end
                end
                default: begin
                    state_d     = ST_RUN;
                    flush_cnt_d = '0;
                end
            endcase
        end
    end

    // RB1 next values: pulses are gated by accept so a stall never duplicates a write or redirect.
    always_comb begin
        rfwr_addr_d   = rfwr_addr_q;
        rfwr_data_d   = rfwr_data_q;
        br_tgt_d      = br_tgt_q;
        mispred_cnt_d = mispred_cnt_q;
        // A mispredicting uop retires but never writes; x0 is hardwired zero.
        rfwr_en_d     = accept_rb0 & (ui_optype == OP_REG) & (ui_opreg != 5'd0) & ~ui_mispred;
        br_mispred_d  = accept_rb0 & ui_mispred;
        instret_d     = instret_q + CNT_W'(accept_rb0);
        if (!stall) begin
            rfwr_addr_d = ui_opreg;
            rfwr_data_d = result_ex1;
            br_tgt_d    = result_ex1[PADDR_W-1:0];
        end
        // Mispredict count saturates rather than wrapping.
        if (br_mispred_d && !(&mispred_cnt_q)) begin
            mispred_cnt_d = mispred_cnt_q + MCNT_W'(1);
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_RUN;
            flush_cnt_q   <= '0;
            rfwr_en_q     <= 1'b0;
            rfwr_addr_q   <= '0;
            rfwr_data_q   <= '0;
            br_mispred_q  <= 1'b0;
            br_tgt_q      <= '0;
            instret_q     <= '0;
            mispred_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            rfwr_en_q     <= rfwr_en_d;
            rfwr_addr_q   <= rfwr_addr_d;
            rfwr_data_q   <= rfwr_data_d;
            br_mispred_q  <= br_mispred_d;
            br_tgt_q      <= br_tgt_d;
            instret_q     <= instret_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign rfwr_en_rb1    = rfwr_en_q;
    assign rfwr_addr_rb1  = rfwr_addr_q;
    assign rfwr_data_rb1  = rfwr_data_q;
    assign br_mispred_rb1 = br_mispred_q;
    assign br_tgt_rb1     = br_tgt_q;
    assign flushing_rb1   = (state_q == ST_FLUSH);
    assign instret        = instret_q;
    assign mispred_cnt    = mispred_cnt_q;

`ifndef SYNTHESIS
    // A redirect never comes with a writeback, and nothing redirects out of a flush window.
    a_redirect_no_write: assert property (@(posedge clk) disable iff (reset)
        br_mispred_rb1 |-> !rfwr_en_rb1);
    a_no_redirect_after_flush: assert property (@(posedge clk) disable iff (reset)
        flushing_rb1 |=> !br_mispred_rb1);
`endif

endmodule

// File: tb/tb_retire_wb.sv
// Directed bench for retire_wb: writeback, redirect, flush squash, stall, reset and counter limits.
// Latency: outputs checked 1 time unit after the edge that registered the driven uop.
// Backpressure: stall is driven directly; no DUT-event waits, every step is a fixed clock tick.
module tb_retire_wb;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [8:0]  uinstr_ex1;
    logic [63:0] result_ex1;
    logic        br_mispred_rb1;
    logic [31:0] br_tgt_rb1;
    logic        rfwr_en_rb1;
    logic [4:0]  rfwr_addr_rb1;
    logic [63:0] rfwr_data_rb1;
    logic        flushing_rb1;
    logic [63:0] instret;
    logic [31:0] mispred_cnt;

    int n_chk = 0;
    int n_err = 0;

    localparam logic [1:0] OPT_NONE = 2'd0;
    localparam logic [1:0] OPT_REG  = 2'd1;

    retire_wb #(.FLUSH_CYCLES(3), .CNT_W(64), .MCNT_W(32), .XLEN(64), .PADDR_W(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .uinstr_ex1     (uinstr_ex1),
        .result_ex1     (result_ex1),
        .br_mispred_rb1 (br_mispred_rb1),
        .br_tgt_rb1     (br_tgt_rb1),
        .rfwr_en_rb1    (rfwr_en_rb1),
        .rfwr_addr_rb1  (rfwr_addr_rb1),
        .rfwr_data_rb1  (rfwr_data_rb1),
        .flushing_rb1   (flushing_rb1),
        .instret        (instret),
        .mispred_cnt    (mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [8:0] uop(input logic v, input logic m, input logic [1:0] t, input logic [4:0] r);
        return {v, m, t, r};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        stall      = 1'b0;
        uinstr_ex1 = '0;
        result_ex1 = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("rst_rfwr_en", 64'(rfwr_en_rb1), 64'd0);
        chk("rst_br", 64'(br_mispred_rb1), 64'd0);
        chk("rst_flushing", 64'(flushing_rb1), 64'd0);
        chk("rst_instret", instret, 64'd0);
        chk("rst_mcnt", 64'(mispred_cnt), 64'd0);

        // 1: ADDI x5 then write to x0
        uinstr_ex1 = uop(1'b1, 1'b0, OPT_REG, 5'd5); result_ex1 = 64'h1234;
        tick();
        chk("t1_en", 64'(rfwr_en_rb1), 64'd1);
        chk("t1_addr", 64'(rfwr_addr_rb1), 64'd5);
        chk("t1_data", rfwr_data_rb1, 64'h1234);
        uinstr_ex1 = uop(1'b1, 1'b0, OPT_REG, 5'd0); result_ex1 = 64'hFFFF;
        tick();
        chk("t1_x0_en", 64'(rfwr_en_rb1), 64'd0);
        chk("t1_instret", instret, 64'd2);
        uinstr_ex1 = '0;

        // 2: mispredicting branch, 3-cycle flush window
        do_reset();
        uinstr_ex1 = uop(1'b1, 1'b1, OPT_NONE, 5'd0); result_ex1 = 64'h8000_0040;
        tick();
        uinstr_ex1 = '0;
        chk("t2_br", 64'(br_mispred_rb1), 64'd1);
        chk("t2_tgt", 64'(br_tgt_rb1), 64'h8000_0040);
        chk("t2_en", 64'(rfwr_en_rb1), 64'd0);
        chk("t2_mcnt", 64'(mispred_cnt), 64'd1);
        chk("t2_instret", instret, 64'd1);
        chk("t2_fl1", 64'(flushing_rb1), 64'd1);
        tick();
        chk("t2_br_pulse", 64'(br_mispred_rb1), 64'd0);
        chk("t2_fl2", 64'(flushing_rb1), 64'd1);
        tick();
        chk("t2_fl3", 64'(flushing_rb1), 64'd1);
        tick();
        chk("t2_fl_end", 64'(flushing_rb1), 64'd0);

        // 3: valid uops during FLUSH are squashed, including a second mispredict
        do_reset();
        uinstr_ex1 = uop(1'b1, 1'b1, OPT_NONE, 5'd0); result_ex1 = 64'h100;
        tick();
        uinstr_ex1 = uop(1'b1, 1'b0, OPT_REG, 5'd9); result_ex1 = 64'hAA;
        tick();
        chk("t3_f1_en", 64'(rfwr_en_rb1), 64'd0);
        uinstr_ex1 = uop(1'b1, 1'b1, OPT_REG, 5'd10); result_ex1 = 64'h200;
        tick();
        chk("t3_f2_en", 64'(rfwr_en_rb1), 64'd0);
        chk("t3_f2_br", 64'(br_mispred_rb1), 64'd0);
        uinstr_ex1 = uop(1'b1, 1'b0, OPT_REG, 5'd11); result_ex1 = 64'hBB;
        tick();
        chk("t3_f3_en", 64'(rfwr_en_rb1), 64'd0);
        chk("t3_f3_br", 64'(br_mispred_rb1), 64'd0);
        chk("t3_run", 64'(flushing_rb1), 64'd0);
        chk("t3_instret_sq", instret, 64'd1);
        chk("t3_mcnt", 64'(mispred_cnt), 64'd1);
        uinstr_ex1 = uop(1'b1, 1'b0, OPT_REG, 5'd12); result_ex1 = 64'h55;
        tick();
        chk("t3_c4_en", 64'(rfwr_en_rb1), 64'd1);
        chk("t3_c4_addr", 64'(rfwr_addr_rb1), 64'd12);
        chk("t3_c4_instret", instret, 64'd2);
        uinstr_ex1 = '0;

        // 4: ADD x7 held through 2 stalled cycles
        do_reset();
        stall = 1'b1;
        uinstr_ex1 = uop(1'b1, 1'b0, OPT_REG, 5'd7); result_ex1 = 64'h77;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("t4_stall_en", 64'(rfwr_en_rb1), 64'd0);
            chk("t4_stall_data", rfwr_data_rb1, 64'd0);
            chk("t4_stall_instret", instret, 64'd0);
        end
        stall = 1'b0;
        tick();
        uinstr_ex1 = '0;
        chk("t4_en", 64'(rfwr_en_rb1), 64'd1);
        chk("t4_addr", 64'(rfwr_addr_rb1), 64'd7);
        chk("t4_data", rfwr_data_rb1, 64'h77);
        chk("t4_instret", instret, 64'd1);
        tick();
        chk("t4_en_once", 64'(rfwr_en_rb1), 64'd0);
        chk("t4_instret_once", instret, 64'd1);

        // 4b: stall + mispredict, then a stall inside FLUSH stretches the window
        do_reset();
        stall = 1'b1;
        uinstr_ex1 = uop(1'b1, 1'b1, OPT_NONE, 5'd0); result_ex1 = 64'h4000;
        tick();
        chk("t4b_stall_br", 64'(br_mispred_rb1), 64'd0);
        chk("t4b_stall_fl", 64'(flushing_rb1), 64'd0);
        stall = 1'b0;
        tick();
        uinstr_ex1 = '0;
        chk("t4b_br", 64'(br_mispred_rb1), 64'd1);
        chk("t4b_tgt", 64'(br_tgt_rb1), 64'h4000);
        stall = 1'b1;
        tick();
        stall = 1'b0;
        tick();
        tick();
        chk("t4b_fl_held", 64'(flushing_rb1), 64'd1);
        tick();
        chk("t4b_fl_end", 64'(flushing_rb1), 64'd0);

        // 5: reset in the 2nd FLUSH cycle
        do_reset();
        uinstr_ex1 = uop(1'b1, 1'b1, OPT_REG, 5'd3); result_ex1 = 64'h8000_0040;
        tick();
        tick();
        chk("t5_pre_fl", 64'(flushing_rb1), 64'd1);
        chk("t5_pre_addr", 64'(rfwr_addr_rb1), 64'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        uinstr_ex1 = '0;
        chk("t5_fl", 64'(flushing_rb1), 64'd0);
        chk("t5_instret", instret, 64'd0);
        chk("t5_mcnt", 64'(mispred_cnt), 64'd0);
        chk("t5_br", 64'(br_mispred_rb1), 64'd0);
        chk("t5_tgt", 64'(br_tgt_rb1), 64'd0);
        chk("t5_en", 64'(rfwr_en_rb1), 64'd0);
        chk("t5_addr", 64'(rfwr_addr_rb1), 64'd0);
        chk("t5_data", rfwr_data_rb1, 64'd0);

        // 6: instret wrap and mispred_cnt saturation
        do_reset();
        force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.instret_q;
        #1;
        chk("t6_preload", instret, 64'hFFFF_FFFF_FFFF_FFFF);
        uinstr_ex1 = uop(1'b1, 1'b0, OPT_REG, 5'd1); result_ex1 = 64'h1;
        tick();
        uinstr_ex1 = '0;
        chk("t6_wrap", instret, 64'd0);
        force dut.mispred_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.mispred_cnt_q;
        #1;
        uinstr_ex1 = uop(1'b1, 1'b1, OPT_NONE, 5'd0); result_ex1 = 64'h2000;
        tick();
        uinstr_ex1 = '0;
        chk("t6_sat_br", 64'(br_mispred_rb1), 64'd1);
        chk("t6_sat", 64'(mispred_cnt), 64'hFFFF_FFFF);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
